// File: rtl/perf_monitor.sv
// perf_monitor: cycle counter from reset release to FINAL_PC, per-channel
// event counters, stuck-PC watchdog and a registered display mux. The
// finished output is the CPU clock gate, so it must be a clean flop output.
module perf_monitor #(
  parameter int PC_WIDTH     = 10,
  parameter int COUNT_WIDTH  = 32,
  parameter int NUM_CHANNELS = 4,
  parameter int FINAL_PC     = 1023,
  parameter int STALL_LIMIT  = 0
) (
  input  logic                                  CLK_50,
  input  logic                                  resetN,
  input  logic [PC_WIDTH-1:0]                   pc,
  input  logic [NUM_CHANNELS-1:0]               events,
  input  logic                                  pause,
  input  logic [$clog2(NUM_CHANNELS+1)-1:0]     sel,
  output logic [COUNT_WIDTH-1:0]                display_value,
  output logic [NUM_CHANNELS:0]                 overflow,
  output logic [1:0]                            state,
  output logic                                  finished,
  output logic                                  timeout
);

  localparam int SEL_WIDTH   = $clog2(NUM_CHANNELS + 1);
  localparam int STALL_WIDTH = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_DONE    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [COUNT_WIDTH-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [COUNT_WIDTH-1:0]   ch_cnt_q [NUM_CHANNELS];
  logic [COUNT_WIDTH-1:0]   ch_cnt_d [NUM_CHANNELS];
  logic [STALL_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;
  logic [PC_WIDTH-1:0]      pc_q, pc_d;
  logic [NUM_CHANNELS:0]    overflow_q, overflow_d;
  logic [COUNT_WIDTH-1:0]   display_value_q, display_value_d;
  logic                     finished_q, finished_d;
  logic                     timeout_q, timeout_d;
  logic                     count_en;
  logic                     wd_fire;

  // Next-state, counter, watchdog and display-mux logic.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d         = state_q;
    cycle_cnt_d     = cycle_cnt_q;
    ch_cnt_d        = ch_cnt_q;
    stall_cnt_d     = stall_cnt_q;
    overflow_d      = overflow_q;
    pc_d            = pc;
    display_value_d = '0;
    wd_fire         = 1'b0;
    count_en        = (state_q == S_RUN) && !pause;

    case (state_q)
      S_IDLE: state_d = S_RUN;

      S_RUN: begin
        // Saturating counters; hitting all-ones raises the sticky flag.
        if (count_en) begin
          if (cycle_cnt_q == '1) overflow_d[0] = 1'b1;
          else                   cycle_cnt_d   = cycle_cnt_q + 1'b1;
        end
        for (int i = 0; i < NUM_CHANNELS; i++) begin
          if (count_en && events[i]) begin
            if (ch_cnt_q[i] == '1) overflow_d[i+1] = 1'b1;
            else                   ch_cnt_d[i]     = ch_cnt_q[i] + 1'b1;
          end
        end

        // Watchdog: a changed PC always clears; pause only freezes the count.
        if (STALL_LIMIT > 0) begin
          if (pc != pc_q) begin
            stall_cnt_d = '0;
          end else if (!pause) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
            wd_fire     = (stall_cnt_q == STALL_WIDTH'(STALL_LIMIT - 1));
          end
        end

        // Reaching FINAL_PC takes precedence over a simultaneous stall.
        if (pc == PC_WIDTH'(FINAL_PC)) state_d = S_DONE;
        else if (wd_fire)              state_d = S_TIMEOUT;
      end

      default: state_d = state_q;
    endcase

    // Display shows the counters as registered before this edge.
    if (sel == '0) display_value_d = cycle_cnt_q;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (sel == SEL_WIDTH'(i + 1)) display_value_d = ch_cnt_q[i];
    end

    finished_d = (state_d == S_DONE) || (state_d == S_TIMEOUT);
    timeout_d  = (state_d == S_TIMEOUT);
  end

  // All state registers with synchronous active-low clear.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK_50) begin
    if (!resetN) begin
      state_q         <= S_IDLE;
      cycle_cnt_q     <= '0;
      stall_cnt_q     <= '0;
      pc_q            <= '0;
      overflow_q      <= '0;
      display_value_q <= '0;
      finished_q      <= 1'b0;
      timeout_q       <= 1'b0;
      // NOTE: the channel counters are a small flop array, not RAM, so
      // clearing them element by element on reset is intended.
      for (int i = 0; i < NUM_CHANNELS; i++) ch_cnt_q[i] <= '0;
    end else begin
      state_q         <= state_d;
      cycle_cnt_q     <= cycle_cnt_d;
      stall_cnt_q     <= stall_cnt_d;
      pc_q            <= pc_d;
      overflow_q      <= overflow_d;
      display_value_q <= display_value_d;
      finished_q      <= finished_d;
      timeout_q       <= timeout_d;
      for (int i = 0; i < NUM_CHANNELS; i++) ch_cnt_q[i] <= ch_cnt_d[i];
    end
  end

  assign display_value = display_value_q;
  assign overflow      = overflow_q;
  assign state         = state_q;
  assign finished      = finished_q;
  assign timeout       = timeout_q;

endmodule
